// File: rtl/tracker_pkg.sv
// ============================================================================
// Module      : tracker_pkg
// Description : Shared definitions for the envelope pulse capture block:
//               FSM state encoding and default widths for the timestamp,
//               pulse-width counter and data-sample shift register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tracker_pkg;

    localparam int TS_W_DEFAULT     = 32;
    localparam int WIDTH_W_DEFAULT  = 16;
    localparam int SAMPLE_W_DEFAULT = 128;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage : tracker_pkg

`default_nettype wire

// File: rtl/envelope_edge_detect.sv
// ============================================================================
// Module      : envelope_edge_detect
// Description : Rise/fall detector for the registered sensor envelope.
//               The history flop resets to 1 so that an envelope that is
//               already high when reset releases never reports a rise.
// Ports       : clk_96MHz  - clock
//               reset      - synchronous active-high reset
//               e_in       - registered envelope
//               rise       - e_in high, previous cycle low
//               fall       - e_in low, previous cycle high
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module envelope_edge_detect (
    input  logic clk_96MHz,
    input  logic reset,
    input  logic e_in,
    output logic rise,
    output logic fall
);

    logic env_prev_q;
    logic env_prev_d;

    always_comb begin
        env_prev_d = e_in;
    end

    always_ff @(posedge clk_96MHz) begin
        if (reset) begin
            env_prev_q <= 1'b1;
        end else begin
            env_prev_q <= env_prev_d;
        end
    end

    assign rise = e_in & ~env_prev_q;
    assign fall = ~e_in & env_prev_q;

endmodule : envelope_edge_detect

`default_nettype wire

// File: rtl/envelope_pulse_capture.sv
// ============================================================================
// Module      : envelope_pulse_capture
// Description : Captures one sensor pulse at a time: start timestamp,
//               saturating width and up to SAMPLE_W data bits (two per
//               cycle). The finished record is offered on a valid/ready
//               handshake and held stable until accepted.
// Ports       : clk_96MHz   - clock
//               reset       - synchronous active-high reset
//               e_in        - registered envelope, active high
//               d_in_0      - data sample, newer of the pair
//               d_in_1      - data sample, older of the pair
//               out_valid   - record available (state DONE)
//               out_ready   - consumer accepts record
//               start_ts    - timestamp of the rise cycle
//               pulse_width - envelope-high cycles, saturating
//               samples     - captured bits, newest in LSB
//               sample_cnt  - number of valid bits in samples
//               truncated   - more than SAMPLE_W bits were offered
//               drop_cnt    - saturating count of pulses lost while pending
// Config      : PULSE_CAPTURE_DROP_CNT_EN - builds the drop counter;
//               otherwise drop_cnt is tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module envelope_pulse_capture
    import tracker_pkg::*;
#(
    parameter int TS_W      = TS_W_DEFAULT,
    parameter int WIDTH_W   = WIDTH_W_DEFAULT,
    parameter int SAMPLE_W  = SAMPLE_W_DEFAULT,
    parameter int MIN_WIDTH = 4
) (
    input  logic                          clk_96MHz,
    input  logic                          reset,
    input  logic                          e_in,
    input  logic                          d_in_0,
    input  logic                          d_in_1,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [TS_W-1:0]               start_ts,
    output logic [WIDTH_W-1:0]            pulse_width,
    output logic [SAMPLE_W-1:0]           samples,
    output logic [$clog2(SAMPLE_W):0]     sample_cnt,
    output logic                          truncated,
    output logic [7:0]                    drop_cnt
);

    localparam int                  C_CNT_W     = $clog2(SAMPLE_W) + 1;
    localparam logic [C_CNT_W-1:0]  C_CNT_MAX   = C_CNT_W'(SAMPLE_W);
    localparam logic [WIDTH_W-1:0]  C_MIN_WIDTH = WIDTH_W'(MIN_WIDTH);

    logic                 w_rise;
    logic                 w_fall;

    state_t               state_q,      state_d;
    logic [TS_W-1:0]      ts_q,         ts_d;
    logic [TS_W-1:0]      start_ts_q,   start_ts_d;
    logic [WIDTH_W-1:0]   width_q,      width_d;
    logic [SAMPLE_W-1:0]  samples_q,    samples_d;
    logic [C_CNT_W-1:0]   sample_cnt_q, sample_cnt_d;
    logic                 truncated_q,  truncated_d;
    logic                 w_start;

    envelope_edge_detect u_edge (
        .clk_96MHz (clk_96MHz),
        .reset     (reset),
        .e_in      (e_in),
        .rise      (w_rise),
        .fall      (w_fall)
    );

    always_comb begin
        state_d      = state_q;
        ts_d         = ts_q + TS_W'(1);
        start_ts_d   = start_ts_q;
        width_d      = width_q;
        samples_d    = samples_q;
        sample_cnt_d = sample_cnt_q;
        truncated_d  = truncated_q;
        w_start      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A level that stays high after an accepted record has no
                // rise, so it is never captured here.
                if (w_rise) begin
                    w_start = 1'b1;
                end
            end
            ST_PULSE: begin
                if (w_fall) begin
                    state_d = (width_q >= C_MIN_WIDTH) ? ST_DONE : ST_IDLE;
                end else if (e_in) begin
                    if (width_q != {WIDTH_W{1'b1}}) begin
                        width_d = width_q + WIDTH_W'(1);
                    end
                    if (sample_cnt_q < C_CNT_MAX) begin
                        samples_d    = {samples_q[SAMPLE_W-3:0], d_in_1, d_in_0};
                        sample_cnt_d = sample_cnt_q + C_CNT_W'(2);
                    end else begin
                        truncated_d  = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                // Record registers are only rewritten once the consumer
                // has taken the current record.
                if (out_ready) begin
                    if (w_rise) begin
                        w_start = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (w_start) begin
            state_d      = ST_PULSE;
            start_ts_d   = ts_q;
            width_d      = WIDTH_W'(1);
            samples_d    = SAMPLE_W'({d_in_1, d_in_0});
            sample_cnt_d = C_CNT_W'(2);
            truncated_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_96MHz) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            ts_q         <= '0;
            start_ts_q   <= '0;
            width_q      <= '0;
            samples_q    <= '0;
            sample_cnt_q <= '0;
            truncated_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            ts_q         <= ts_d;
            start_ts_q   <= start_ts_d;
            width_q      <= width_d;
            samples_q    <= samples_d;
            sample_cnt_q <= sample_cnt_d;
            truncated_q  <= truncated_d;
        end
    end

    assign out_valid   = (state_q == ST_DONE);
    assign start_ts    = start_ts_q;
    assign pulse_width = width_q;
    assign samples     = samples_q;
    assign sample_cnt  = sample_cnt_q;
    assign truncated   = truncated_q;

`ifdef PULSE_CAPTURE_DROP_CNT_EN
    logic [7:0] drop_cnt_q;
    logic [7:0] drop_cnt_d;

    // A rise while a record is still waiting for the consumer is lost.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if ((state_q == ST_DONE) && w_rise && !out_ready && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_96MHz) begin
        if (reset) begin
            drop_cnt_q <= 8'd0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`else
    assign drop_cnt = 8'd0;
`endif

endmodule : envelope_pulse_capture

`default_nettype wire

// File: tb/tb_envelope_pulse_capture.sv
// ============================================================================
// Module      : tb_envelope_pulse_capture
// Description : Directed self-checking bench for envelope_pulse_capture.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_envelope_pulse_capture;

    logic         clk_96MHz = 1'b0;
    logic         reset     = 1'b1;
    logic         e_in      = 1'b0;
    logic         d_in_0    = 1'b0;
    logic         d_in_1    = 1'b0;
    logic         out_ready = 1'b0;
    logic         out_valid;
    logic [31:0]  start_ts;
    logic [15:0]  pulse_width;
    logic [127:0] samples;
    logic [7:0]   sample_cnt;
    logic         truncated;
    logic [7:0]   drop_cnt;

    int checks   = 0;
    int failures = 0;

    logic [31:0]  ts_model = 32'd0;
    logic [31:0]  exp_start;
    logic [15:0]  exp_width;
    logic [127:0] exp_samples;
    logic [7:0]   exp_cnt;
    logic         exp_trunc;
    logic [7:0]   exp_drop;

    envelope_pulse_capture dut (
        .clk_96MHz   (clk_96MHz),
        .reset       (reset),
        .e_in        (e_in),
        .d_in_0      (d_in_0),
        .d_in_1      (d_in_1),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .start_ts    (start_ts),
        .pulse_width (pulse_width),
        .samples     (samples),
        .sample_cnt  (sample_cnt),
        .truncated   (truncated),
        .drop_cnt    (drop_cnt)
    );

    always #5 clk_96MHz = ~clk_96MHz;

    // One clock: the model timestamp tracks what the DUT sees at the edge.
    task automatic step();
        @(posedge clk_96MHz);
        if (reset) ts_model = 32'd0;
        else       ts_model = ts_model + 32'd1;
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // mode 1: first cycle starts a new expected record
    // mode 0: continues the expected record
    // mode 2: pulse is not expected to be captured
    task automatic drive_high(input int n, input int mode, input int seed);
        logic [1:0] pr;
        for (int i = 0; i < n; i++) begin
            pr     = 2'((i + seed) & 3);
            e_in   = 1'b1;
            d_in_1 = pr[1];
            d_in_0 = pr[0];
            if (mode == 1 && i == 0) begin
                exp_start   = ts_model;
                exp_width   = 16'd1;
                exp_samples = {126'd0, pr};
                exp_cnt     = 8'd2;
                exp_trunc   = 1'b0;
            end else if (mode != 2) begin
                if (exp_width != 16'hFFFF) exp_width = exp_width + 16'd1;
                if (exp_cnt < 8'd128) begin
                    exp_samples = {exp_samples[125:0], pr};
                    exp_cnt     = exp_cnt + 8'd2;
                end else begin
                    exp_trunc = 1'b1;
                end
            end
            step();
        end
    endtask

    task automatic fall();
        e_in   = 1'b0;
        d_in_0 = 1'b0;
        d_in_1 = 1'b0;
        step();
    endtask

    task automatic check_record(input string tag);
        chk({tag, ".out_valid"},   128'(out_valid),   128'(1'b1));
        chk({tag, ".start_ts"},    128'(start_ts),    128'(exp_start));
        chk({tag, ".pulse_width"}, 128'(pulse_width), 128'(exp_width));
        chk({tag, ".samples"},     samples,           exp_samples);
        chk({tag, ".sample_cnt"},  128'(sample_cnt),  128'(exp_cnt));
        chk({tag, ".truncated"},   128'(truncated),   128'(exp_trunc));
    endtask

    task automatic accept();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
`ifdef PULSE_CAPTURE_DROP_CNT_EN
        exp_drop = 8'd2;
`else
        exp_drop = 8'd0;
`endif
        // Reset state
        reset = 1'b1;
        step(); step(); step();
        chk("rst.out_valid",   128'(out_valid),   128'd0);
        chk("rst.start_ts",    128'(start_ts),    128'd0);
        chk("rst.pulse_width", 128'(pulse_width), 128'd0);
        chk("rst.samples",     samples,           128'd0);
        chk("rst.sample_cnt",  128'(sample_cnt),  128'd0);
        chk("rst.truncated",   128'(truncated),   128'd0);
        chk("rst.drop_cnt",    128'(drop_cnt),    128'd0);
        reset = 1'b0;

        // Basic 10-cycle pulse starting at ts=100
        while (ts_model != 32'd100) step();
        drive_high(10, 1, 0);
        chk("t1.pre_fall_valid", 128'(out_valid), 128'd0);
        fall();
        check_record("t1");
        chk("t1.start_100", 128'(start_ts),    128'd100);
        chk("t1.width_10",  128'(pulse_width), 128'd10);
        chk("t1.cnt_20",    128'(sample_cnt),  128'd20);
        step(); step(); step();
        check_record("t1.hold");
        accept();
        chk("t1.accepted_valid", 128'(out_valid), 128'd0);

        // Glitch shorter than MIN_WIDTH is discarded
        drive_high(3, 2, 1);
        fall();
        chk("t2.glitch_valid0", 128'(out_valid), 128'd0);
        step(); step();
        chk("t2.glitch_valid1", 128'(out_valid), 128'd0);

        // Exactly MIN_WIDTH is accepted
        drive_high(4, 1, 2);
        fall();
        check_record("t2b");
        accept();

        // 70-cycle pulse truncates at 128 bits
        drive_high(70, 1, 3);
        fall();
        check_record("t3");
        chk("t3.cnt_128", 128'(sample_cnt), 128'd128);
        chk("t3.trunc_1", 128'(truncated),  128'd1);
        accept();

        // 64-cycle pulse fills exactly, no truncation
        drive_high(64, 1, 1);
        fall();
        check_record("t3b");
        chk("t3b.trunc_0", 128'(truncated), 128'd0);
        accept();

        // Two pulses while a record is pending
        drive_high(6, 1, 2);
        fall();
        step(); step();
        drive_high(5, 2, 0);
        fall();
        step();
        drive_high(7, 2, 1);
        fall();
        step();
        check_record("t4");
        chk("t4.drop_cnt", 128'(drop_cnt), 128'(exp_drop));

        // Acceptance and rise in the same cycle
        out_ready = 1'b1;
        drive_high(1, 1, 3);
        out_ready = 1'b0;
        chk("t5.valid_after_accept", 128'(out_valid), 128'd0);
        drive_high(5, 0, 1);
        fall();
        check_record("t5");
        chk("t5.drop_cnt", 128'(drop_cnt), 128'(exp_drop));
        accept();

        // Envelope high through reset release
        reset = 1'b1;
        e_in  = 1'b1;
        step(); step();
        reset = 1'b0;
        drive_high(6, 2, 0);
        fall();
        chk("t6.high_at_release0", 128'(out_valid), 128'd0);
        step();
        chk("t6.high_at_release1", 128'(out_valid), 128'd0);

        // Reset mid-pulse
        drive_high(5, 2, 0);
        reset = 1'b1;
        e_in  = 1'b0;
        step();
        reset = 1'b0;
        step(); step();
        chk("t6.midpulse_valid", 128'(out_valid),   128'd0);
        chk("t6.midpulse_width", 128'(pulse_width), 128'd0);

        // Reset while a record is pending
        drive_high(5, 1, 1);
        fall();
        chk("t6.done_valid", 128'(out_valid), 128'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t6.middone_valid", 128'(out_valid), 128'd0);
        chk("t6.middone_ts",    128'(start_ts),  128'd0);
        chk("t6.middone_drop",  128'(drop_cnt),  128'd0);
        step();
        chk("t6.middone_valid2", 128'(out_valid), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_envelope_pulse_capture

`default_nettype wire
